// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default geometry for the data-memory access controller.
package dmem_pkg;
  localparam int NBITS_O_DEF = 11;
  localparam int NBITS_D_DEF = 16;
  localparam int CELDAS_DEF  = 512;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RDV  = 3'd4,
    S_DRD1 = 3'd5,
    S_DRD2 = 3'd6,
    S_DOUT = 3'd7
  } state_t;
endpackage

// File: rtl/dmem_addr_counter.sv
// dmem_addr_counter: dump address counter with clear, saturating increment and last-cell flag.
module dmem_addr_counter #(
  parameter int NBITS  = 11,
  parameter int CELDAS = 512
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [NBITS-1:0] o_count,
  output logic             o_last
);
  logic [NBITS-1:0] r_count;
  assign o_count = r_count;
  assign o_last  = r_count == NBITS'(CELDAS - 1);
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_inc && !o_last) r_count <= r_count + 1'b1;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: turns valid/ready read/write requests into memory strobes and
// sweeps the whole memory out to the debug unit in dump mode.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int NBITS_O = NBITS_O_DEF,
  parameter int NBITS_D = NBITS_D_DEF,
  parameter int CELDAS  = CELDAS_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_ReqValid,
  output logic               o_ReqReady,
  input  logic               i_ReqWr,
  input  logic [NBITS_O-1:0] i_ReqAdd,
  input  logic [NBITS_D-1:0] i_ReqData,
  output logic               o_WrDone,
  output logic               o_RdValid,
  output logic [NBITS_D-1:0] o_RdData,
  input  logic               i_DumpStart,
  output logic               o_DumpValid,
  input  logic               i_DumpReady,
  output logic [NBITS_D-1:0] o_DumpData,
  output logic [NBITS_O-1:0] o_DumpAdd,
  output logic               o_DumpDone,
  output logic               o_Busy,
  output logic               o_MemRd,
  output logic               o_MemWr,
  output logic [NBITS_O-1:0] o_MemAdd,
  output logic [NBITS_D-1:0] o_MemInData,
  input  logic [NBITS_D-1:0] i_MemOutData
);
  state_t r_state, w_next;
  logic [NBITS_O-1:0] r_add, w_count;
  logic [NBITS_D-1:0] r_data, r_cap;
  logic r_done, w_last, w_idle, w_dump_start, w_dump_hs, w_accept, w_dumping;
  assign w_idle       = r_state == S_IDLE;
  assign w_dump_start = w_idle && i_DumpStart;
  assign w_dump_hs    = r_state == S_DOUT && i_DumpReady;
  assign w_accept     = i_ReqValid && o_ReqReady;
  assign w_dumping    = r_state == S_DRD1 || r_state == S_DRD2 || r_state == S_DOUT;
  dmem_addr_counter #(.NBITS(NBITS_O), .CELDAS(CELDAS)) u_cnt (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_clear(w_dump_start),
    .i_inc  (w_dump_hs),
    .o_count(w_count),
    .o_last (w_last)
  );
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_DumpStart ? S_DRD1 : i_ReqValid ? (i_ReqWr ? S_WR : S_RD1) : S_IDLE;
      S_WR:    w_next = S_IDLE;
      S_RD1:   w_next = S_RD2;
      S_RD2:   w_next = S_RDV;
      S_RDV:   w_next = S_IDLE;
      S_DRD1:  w_next = S_DRD2;
      S_DRD2:  w_next = S_DOUT;
      S_DOUT:  w_next = i_DumpReady ? (w_last ? S_IDLE : S_DRD1) : S_DOUT;
      default: w_next = S_IDLE;
    endcase
  end
  // Dump start has priority, so ready drops combinationally in that cycle.
  always_comb begin
    o_ReqReady  = w_idle && !i_DumpStart;
    o_Busy      = !w_idle;
    o_MemWr     = r_state == S_WR;
    o_WrDone    = r_state == S_WR;
    o_MemRd     = r_state == S_RD1 || r_state == S_RD2 || r_state == S_DRD1 || r_state == S_DRD2;
    o_RdValid   = r_state == S_RDV;
    o_DumpValid = r_state == S_DOUT;
    o_MemAdd    = w_dumping ? w_count : r_add;
    o_MemInData = r_data;
    o_RdData    = r_cap;
    o_DumpData  = r_cap;
    o_DumpAdd   = w_count;
    o_DumpDone  = r_done;
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_add  <= '0;
      r_data <= '0;
      r_cap  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_add  <= i_ReqAdd;
        r_data <= i_ReqData;
      end
      if (r_state == S_RD2 || r_state == S_DRD2) r_cap <= i_MemOutData;
      r_done <= w_dump_hs && w_last;
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed + random checks of dmem_access_ctrl against a shadow memory.
module tb_dmem_access_ctrl;
  localparam int NO = 11, ND = 16, NC = 8;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wr = 0, dump_start = 0, dump_ready = 0;
  logic [NO-1:0] req_add = '0;
  logic [ND-1:0] req_data = '0;
  logic req_ready, wr_done, rd_valid, dump_valid, dump_done, busy, mem_rd, mem_wr;
  logic [ND-1:0] rd_data, dump_data, mem_in, mem_out = '0;
  logic [NO-1:0] dump_add, mem_add;
  logic [ND-1:0] mem [2**NO];
  logic [ND-1:0] ref_mem [2**NO];
  int checks = 0, errors = 0, done_cnt = 0;

  dmem_access_ctrl #(.NBITS_O(NO), .NBITS_D(ND), .CELDAS(NC)) dut (
    .i_clock(clk), .i_reset(rst), .i_ReqValid(req_valid), .o_ReqReady(req_ready),
    .i_ReqWr(req_wr), .i_ReqAdd(req_add), .i_ReqData(req_data), .o_WrDone(wr_done),
    .o_RdValid(rd_valid), .o_RdData(rd_data), .i_DumpStart(dump_start),
    .o_DumpValid(dump_valid), .i_DumpReady(dump_ready), .o_DumpData(dump_data),
    .o_DumpAdd(dump_add), .o_DumpDone(dump_done), .o_Busy(busy), .o_MemRd(mem_rd),
    .o_MemWr(mem_wr), .o_MemAdd(mem_add), .o_MemInData(mem_in), .i_MemOutData(mem_out)
  );

  always #5 clk = ~clk;

  // Memory updates its output only while Rd is high.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_add] <= mem_in;
    if (mem_rd) mem_out <= mem[mem_add];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_overlap", {31'd0, mem_rd & mem_wr}, 0);
    if (dump_done) done_cnt++;
  endtask

  task automatic do_write(input logic [NO-1:0] a, input logic [ND-1:0] d);
    req_valid = 1; req_wr = 1; req_add = a; req_data = d;
    chk("wr_ready", {31'd0, req_ready}, 1);
    tick();
    req_valid = 0; req_add = '0; req_data = '0;
    chk("wr_strobe", {31'd0, mem_wr}, 1);
    chk("wr_done", {31'd0, wr_done}, 1);
    chk("wr_add", {21'd0, mem_add}, {21'd0, a});
    chk("wr_data", {16'd0, mem_in}, {16'd0, d});
    ref_mem[a] = d;
    tick();
    chk("wr_idle", {30'd0, mem_wr, busy}, 0);
  endtask

  task automatic do_read(input logic [NO-1:0] a);
    req_valid = 1; req_wr = 0; req_add = a;
    chk("rd_ready", {31'd0, req_ready}, 1);
    tick();
    req_valid = 0; req_add = '0;
    chk("rd_strobe1", {30'd0, mem_rd, rd_valid}, 2);
    chk("rd_add", {21'd0, mem_add}, {21'd0, a});
    tick();
    chk("rd_strobe2", {30'd0, mem_rd, rd_valid}, 2);
    tick();
    chk("rd_valid", {30'd0, mem_rd, rd_valid}, 1);
    chk("rd_data", {16'd0, rd_data}, {16'd0, ref_mem[a]});
    tick();
    chk("rd_after", {30'd0, rd_valid, busy}, 0);
  endtask

  initial begin
    for (int i = 0; i < 2**NO; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    #12;
    chk("reset_ready", {31'd0, req_ready}, 1);
    chk("reset_ctl", {24'd0, wr_done, rd_valid, dump_valid, dump_done, busy, mem_rd, mem_wr, 1'b0}, 0);
    chk("reset_data", {rd_data, mem_in}, 0);
    chk("reset_add", {5'd0, mem_add, dump_add}, 0);
    rst = 0;
    tick();
    do_write(11'h005, 16'hBEEF);
    do_read(11'h005);
    // Reset in the middle of RD2.
    req_valid = 1; req_wr = 0; req_add = 11'h005;
    tick();
    req_valid = 0;
    tick();
    chk("pre_reset_rd2", {31'd0, mem_rd}, 1);
    #2 rst = 1;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 1);
    chk("midrst_ctl", {25'd0, wr_done, rd_valid, dump_valid, dump_done, busy, mem_rd, mem_wr}, 0);
    chk("midrst_data", {rd_data, mem_in}, 0);
    #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_valid", {29'd0, rd_valid, mem_rd, busy}, 0);
    end
    // Back-to-back requests held valid.
    req_valid = 1; req_wr = 1; req_add = 11'h100; req_data = 16'h1234;
    chk("b2b_ready0", {31'd0, req_ready}, 1);
    tick();
    ref_mem[11'h100] = 16'h1234;
    chk("b2b_wr_busy", {30'd0, req_ready, mem_wr}, 1);
    req_wr = 0;
    tick();
    chk("b2b_idle", {29'd0, req_ready, busy, mem_wr}, 4);
    tick();
    req_valid = 0;
    chk("b2b_rd", {30'd0, req_ready, mem_rd}, 1);
    tick();
    tick();
    chk("b2b_rd_valid", {31'd0, rd_valid}, 1);
    chk("b2b_rd_data", {16'd0, rd_data}, 32'h1234);
    tick();
    // Random traffic against the shadow memory.
    for (int i = 0; i < 20; i++) begin
      logic [NO-1:0] a;
      a = NO'($urandom_range(NC, 2**NO - 1));
      if ($urandom_range(0, 2) != 0) do_write(a, ND'($urandom));
      else do_read(a);
    end
    do_read(11'h100);
    for (int k = 0; k < NC; k++) do_write(NO'(k), ND'(k * 16'h11));
    // Dump racing a read request; dump must win.
    dump_start = 1; req_valid = 1; req_wr = 0; req_add = 11'h003;
    #1;
    chk("dump_prio_ready", {31'd0, req_ready}, 0);
    tick();
    dump_start = 0; dump_ready = 1; done_cnt = 0;
    for (int k = 0; k < NC; k++) begin
      int n;
      if (k == 3) dump_ready = 0;
      n = 0;
      while (!dump_valid && n < 8) begin
        chk("dump_busy_ready", {31'd0, req_ready}, 0);
        tick();
        n++;
      end
      chk("dump_valid", {31'd0, dump_valid}, 1);
      chk("dump_add", {21'd0, dump_add}, k);
      chk("dump_data", {16'd0, dump_data}, {16'd0, ref_mem[k]});
      if (k == 3) begin
        repeat (5) begin
          tick();
          chk("dump_hold", {15'd0, dump_valid, dump_data}, 32'h1_0033);
        end
        dump_ready = 1;
      end
      tick();
    end
    dump_ready = 0;
    chk("dump_done", {31'd0, dump_done}, 1);
    chk("dump_done_ready", {30'd0, req_ready, busy}, 2);
    tick();
    req_valid = 0;
    chk("post_dump_rd", {31'd0, mem_rd}, 1);
    chk("post_dump_add", {21'd0, mem_add}, 3);
    tick();
    tick();
    chk("post_dump_valid", {15'd0, rd_valid, rd_data}, 32'h1_0033);
    tick();
    chk("dump_done_once", done_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
